// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU (operand reg -> result reg) with NZCV flags and tag passthrough.
// Define ALU_MUL_EN to add the iterative shift-add multiply on opcode 1000; otherwise 1000 is illegal.
module alu_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [3:0]       nzcv,
    output logic             illegal,
    output logic [TAG_W-1:0] tag_out
);
    localparam logic [3:0] OP_AND = 4'b0000, OP_ORR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_PASS = 4'b0111, OP_NOR = 4'b1100;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
`else
    typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d, r;
    logic [3:0]       s_q, s_d, nzcv_q, nzcv_d;
    logic [TAG_W-1:0] tag_q, tag_d, tag_out_q, tag_out_d;
    logic             out_valid_q, out_valid_d, ill_q, ill_d;
    logic             s1_valid, done1, adv2, accept, c, v, ill;
    logic [WIDTH:0]   sum, dif;

    assign s1_valid  = state_q != IDLE;
    assign done1     = state_q == EXEC;
    assign adv2      = s1_valid && done1 && (!out_valid_q || out_ready);
    assign in_ready  = !s1_valid || adv2;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign nzcv      = nzcv_q;
    assign illegal   = ill_q;
    assign tag_out   = tag_out_q;

    always_comb begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        dif = {1'b0, a_q} - {1'b0, b_q};
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        case (s_q)
            OP_AND:  r = a_q & b_q;
            OP_ORR:  r = a_q | b_q;
            OP_ADD: begin
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                r = dif[WIDTH-1:0];
                c = !dif[WIDTH];
                v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_PASS: r = b_q;
            OP_NOR:  r = ~(a_q | b_q);
`ifdef ALU_MUL_EN
            OP_MUL:  r = acc_q;
`endif
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        tag_d   = tag_q;
        if (accept) begin
            state_d = EXEC;
            a_d     = a;
            b_d     = b;
            s_d     = s;
            tag_d   = tag_in;
`ifdef ALU_MUL_EN
            if (s == OP_MUL) state_d = MUL;
`endif
        end else if (adv2) begin
            state_d = IDLE;
        end
`ifdef ALU_MUL_EN
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (accept) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (state_q == MUL) begin
            // a shifts right and b left so each step only looks at a[0]
            acc_d = acc_q + (a_q[0] ? b_q : '0);
            a_d   = a_q >> 1;
            b_d   = b_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = EXEC;
        end
`endif
        out_valid_d = adv2 || (out_valid_q && !out_ready);
        z_d         = adv2 ? r : z_q;
        nzcv_d      = adv2 ? {r[WIDTH-1], r == '0, c, v} : nzcv_q;
        ill_d       = adv2 ? ill : ill_q;
        tag_out_d   = adv2 ? tag_q : tag_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            nzcv_q      <= '0;
            ill_q       <= 1'b0;
            tag_out_q   <= '0;
`ifdef ALU_MUL_EN
            cnt_q       <= '0;
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            nzcv_q      <= nzcv_d;
            ill_q       <= ill_d;
            tag_out_q   <= tag_out_d;
`ifdef ALU_MUL_EN
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table vectors, hand-written pipeline sequences and random traffic for alu_pipe.
// Follows ALU_MUL_EN the same way the design does.
module tb_alu_pipe;
    localparam int W = 64;
`ifdef ALU_MUL_EN
    localparam int LAT = W + 2;
    localparam logic [W-1:0] MUL_Z = 64'd21;
    localparam logic MUL_ILL = 1'b0;
`else
    localparam int LAT = 2;
    localparam logic [W-1:0] MUL_Z = 64'd0;
    localparam logic MUL_ILL = 1'b1;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, illegal;
    logic [W-1:0] a = '0, b = '0, z;
    logic [3:0] s = '0, tag_in = '0, tag_out, nzcv;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .nzcv(nzcv), .illegal(illegal), .tag_out(tag_out)
    );

    typedef struct packed {
        logic [W-1:0] z;
        logic [3:0]   nzcv;
        logic         ill;
        logic [3:0]   tag;
    } res_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic [3:0]   s;
        logic [W-1:0] z;
        logic [3:0]   nzcv;
        logic         ill;
    } vec_t;

    res_t q[$];
    vec_t tbl[12];
    logic [3:0] ops[9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b0011, 4'b1111};

    function automatic res_t model(input logic [W-1:0] x, y, input logic [3:0] op, t);
        res_t r;
        logic c, v;
        logic [W+1:0] sw;
        r.tag = t;
        r.ill = 1'b0;
        r.z   = '0;
        c     = 1'b0;
        v     = 1'b0;
        sw    = '0;
        case (op)
            4'b0000: r.z = x & y;
            4'b0001: r.z = x | y;
            4'b0010: begin
                r.z = x + y;
                c   = r.z < x;
                sw  = {{2{x[W-1]}}, x} + {{2{y[W-1]}}, y};
                v   = sw != {{2{r.z[W-1]}}, r.z};
            end
            4'b0110: begin
                r.z = x - y;
                c   = x >= y;
                sw  = {{2{x[W-1]}}, x} - {{2{y[W-1]}}, y};
                v   = sw != {{2{r.z[W-1]}}, r.z};
            end
            4'b0111: r.z = y;
            4'b1100: r.z = ~(x | y);
`ifdef ALU_MUL_EN
            4'b1000: r.z = x * y;
`endif
            default: r.ill = 1'b1;
        endcase
        r.nzcv = {r.z[W-1], r.z == '0, c, v};
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return W'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, then score what the next posedge will transfer.
    task automatic step(input logic iv, input logic [W-1:0] ia, ib, input logic [3:0] is,
                        input res_t e, input logic ordy, output logic acc);
        res_t exp, got;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        s         = is;
        tag_in    = e.tag;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (acc) q.push_back(e);
        if (out_valid && out_ready) begin
            checks++;
            got = {z, nzcv, illegal, tag_out};
            if (q.size() == 0) begin
                errors++;
                $display("FAIL result: got unexpected tag %0d z %h, expected no result", tag_out, z);
            end else begin
                exp = q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL result: got z %h nzcv %b ill %b tag %0d expected z %h nzcv %b ill %b tag %0d",
                             got.z, got.nzcv, got.ill, got.tag, exp.z, exp.nzcv, exp.ill, exp.tag);
                end
            end
        end
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, '0, '0, '0, '0, ordy, acc);
    endtask

    task automatic offer(input logic [W-1:0] ia, ib, input logic [3:0] is, input res_t e,
                         input logic ordy, output int n);
        logic acc;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            step(1'b1, ia, ib, is, e, ordy, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept in %0d cycles expected accept", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            idle(1'b1);
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic acc;
        tbl[0]  = '{64'd0, 64'd1, 4'b1100, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0};
        tbl[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'h8000_0000_0000_0000, 4'b1001, 1'b0};
        tbl[2]  = '{64'd5, 64'd5, 4'b0110, 64'd0, 4'b0110, 1'b0};
        tbl[3]  = '{64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b0000, 64'hF000_F000_F000_F000, 4'b1000, 1'b0};
        tbl[4]  = '{64'h0F0, 64'h00F, 4'b0001, 64'h0FF, 4'b0000, 1'b0};
        tbl[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 4'b0110, 1'b0};
        tbl[6]  = '{64'd3, 64'd5, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0};
        tbl[7]  = '{64'h8000_0000_0000_0000, 64'd1, 4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0};
        tbl[8]  = '{64'd123, 64'd0, 4'b0111, 64'd0, 4'b0100, 1'b0};
        tbl[9]  = '{64'd5, 64'd6, 4'b0011, 64'd0, 4'b0100, 1'b1};
        tbl[10] = '{64'd5, 64'd6, 4'b1111, 64'd0, 4'b0100, 1'b1};
        tbl[11] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b0010, 64'd0, 4'b0111, 1'b0};

        #12;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_z", z, 64'd0);
        chk("rst_nzcv", 64'(nzcv), 64'd0);
        chk1("rst_illegal", illegal, 1'b0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        chk1("ready_after_reset", in_ready, 1'b1);

        for (int i = 0; i < 12; i++) begin
            offer(tbl[i].a, tbl[i].b, tbl[i].s, {tbl[i].z, tbl[i].nzcv, tbl[i].ill, 4'(i + 1)}, 1'b1, n);
            chk("tbl_throughput", 64'(n), 64'd1);
        end
        drain();

        offer(64'd1, 64'd2, 4'b0010, model(64'd1, 64'd2, 4'b0010, 4'd1), 1'b0, n);
        chk("bp_accept1", 64'(n), 64'd1);
        offer(64'hF0, 64'h0F, 4'b0001, model(64'hF0, 64'h0F, 4'b0001, 4'd2), 1'b0, n);
        chk("bp_accept2", 64'(n), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 64'd9, 64'd4, 4'b0110, model(64'd9, 64'd4, 4'b0110, 4'd3), 1'b0, acc);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_out_valid", out_valid, 1'b1);
            chk("bp_z_frozen", z, 64'd3);
            chk("bp_tag_frozen", 64'(tag_out), 64'd1);
        end
        offer(64'd9, 64'd4, 4'b0110, model(64'd9, 64'd4, 4'b0110, 4'd3), 1'b1, n);
        chk("bp_accept3", 64'(n), 64'd1);
        drain();

        offer(64'd3, 64'd7, 4'b1000, model(64'd3, 64'd7, 4'b1000, 4'd6), 1'b1, n);
        n = 0;
        do begin
            idle(1'b1);
            n++;
            if (n <= LAT - 2) chk1("mul_in_ready", in_ready, 1'b0);
        end while (!out_valid && n < 200);
        chk("mul_latency", 64'(n), 64'(LAT));
        chk("mul_z", z, MUL_Z);
        chk1("mul_illegal", illegal, MUL_ILL);
        drain();

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            logic [W-1:0] x, y;
            op = ops[$urandom_range(0, 8)];
            x = pick();
            y = pick();
            step($urandom_range(0, 3) != 0, x, y, op, model(x, y, op, 4'(i)), $urandom_range(0, 3) != 0, acc);
        end
        drain();

        offer(64'd10, 64'd5, 4'b0110, model(64'd10, 64'd5, 4'b0110, 4'd9), 1'b0, n);
        offer(64'd3, 64'd7, 4'b1000, model(64'd3, 64'd7, 4'b1000, 4'd10), 1'b0, n);
        idle(1'b0);
        idle(1'b0);
        chk1("pre_rst_out_valid", out_valid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_z", z, 64'd0);
        chk("mid_rst_nzcv", 64'(nzcv), 64'd0);
        chk1("mid_rst_illegal", illegal, 1'b0);
        chk("mid_rst_tag", 64'(tag_out), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        chk1("ready_after_rst2", in_ready, 1'b1);
        offer(64'd100, 64'd23, 4'b0010, model(64'd100, 64'd23, 4'b0010, 4'd11), 1'b1, n);
        n = 0;
        do begin
            idle(1'b1);
            n++;
        end while (!out_valid && n < 20);
        chk("post_rst_latency", 64'(n), 64'd2);
        chk("post_rst_z", z, 64'd123);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
